// File: rtl/fifo_uart_tx.sv
// FIFO drain that pops one word at a time and sends it over an 8N1 UART line,
// most-significant byte first, each byte LSB first.
module fifo_uart_tx #(
  parameter int width        = 16,
  parameter int clks_per_bit = 434
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_done,
  input  logic             tx_hold,
  output logic             txd,
  output logic             busy
);

  localparam int nbytes = width / 8;
  localparam int baud_w = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int byte_w = (nbytes > 1) ? $clog2(nbytes) : 1;
  localparam logic [baud_w-1:0] baud_last = baud_w'(clks_per_bit - 1);
  localparam logic [byte_w-1:0] byte_last = byte_w'(nbytes - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [width-1:0]  shreg, shreg_n;
  logic [baud_w-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [byte_w-1:0] byte_cnt, byte_cnt_n;
  logic              txd_n;
  logic              busy_n;
  logic              baud_end;
  logic [7:0]        cur_byte;

  assign fifo_rd_done = reset & (state == IDLE) & ~fifo_empty & ~tx_hold;
  assign baud_end     = (baud_cnt == baud_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      txd      <= txd_n;
      busy     <= busy_n;
    end
  end

  // txd is registered, so it is derived from the next-state values.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;

    case (state)
      IDLE: begin
        if (fifo_rd_done) begin
          shreg_n    = fifo_data;
          byte_cnt_n = '0;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          if (byte_cnt != byte_last) begin
            byte_cnt_n = byte_cnt + 1'b1;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Byte 0 is the most significant byte of the captured word.
    cur_byte = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (byte_cnt_n == byte_w'(i)) cur_byte = shreg_n[width-1-8*i -: 8];
    end

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = cur_byte[bit_cnt_n];
      default: txd_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: small FIFO models feed two instances
// (16-bit and 32-bit words) and a scoreboard checks every UART bit cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic tx_hold;

  logic [15:0] mem_a [0:15];
  logic [3:0]  wr_a = '0;
  logic [3:0]  rd_a = '0;
  logic [15:0] fifo_data_a;
  logic        fifo_empty_a;
  logic        rd_done_a, txd_a, busy_a;

  logic [31:0] mem_b [0:15];
  logic [3:0]  wr_b = '0;
  logic [3:0]  rd_b = '0;
  logic [31:0] fifo_data_b;
  logic        fifo_empty_b;
  logic        rd_done_b, txd_b, busy_b;

  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_data_a  = mem_a[rd_a];
  assign fifo_empty_b = (wr_b == rd_b);
  assign fifo_data_b  = mem_b[rd_b];

  always @(posedge clk) begin
    if (rd_done_a) rd_a <= rd_a + 4'd1;
    if (rd_done_b) rd_b <= rd_b + 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx #(.width(16), .clks_per_bit(CPB)) dut_a (
    .clk(clk), .reset(reset), .fifo_data(fifo_data_a), .fifo_empty(fifo_empty_a),
    .fifo_rd_done(rd_done_a), .tx_hold(tx_hold), .txd(txd_a), .busy(busy_a)
  );

  fifo_uart_tx #(.width(32), .clks_per_bit(CPB)) dut_b (
    .clk(clk), .reset(reset), .fifo_data(fifo_data_b), .fifo_empty(fifo_empty_b),
    .fifo_rd_done(rd_done_b), .tx_hold(tx_hold), .txd(txd_b), .busy(busy_b)
  );

  logic sel = 1'b0;
  logic mon_txd, mon_busy, mon_rd;
  always_comb begin
    mon_txd  = sel ? txd_b : txd_a;
    mon_busy = sel ? busy_b : busy_a;
    mon_rd   = sel ? rd_done_b : rd_done_a;
  end

  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int last_pop = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic which, input logic [31:0] w);
    if (which == 1'b0) begin
      mem_a[wr_a] = w[15:0];
      wr_a = wr_a + 4'd1;
    end else begin
      mem_b[wr_b] = w;
      wr_b = wr_b + 4'd1;
    end
    exp_q.push_back(w);
    #1;
  endtask

  task automatic waitPop(output logic found, output logic [31:0] word);
    found = 1'b0;
    word  = '0;
    for (int k = 0; k < 200; k++) begin
      if (mon_rd === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("pop_seen", 32'(found), 32'd1);
    if (found) begin
      last_pop = cyc;
      checkOutput("busy_at_pop", 32'(mon_busy), 32'd0);
      checkOutput("txd_at_pop", 32'(mon_txd), 32'd1);
      if (exp_q.size() > 0) word = exp_q.pop_front();
    end
  endtask

  task automatic checkWord(input int nb, input int hold_at);
    logic        found;
    logic [31:0] w;
    logic [7:0]  bv;
    logic        expb;
    int          n;
    waitPop(found, w);
    if (!found) return;
    n = 0;
    for (int b = 0; b < nb; b++) begin
      bv = 8'(w >> (8 * (nb - 1 - b)));
      for (int i = 0; i < 10; i++) begin
        expb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : bv[i-1];
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          if (n == hold_at) tx_hold = 1'b1;
          n++;
          checkOutput("txd_bit", 32'(mon_txd), 32'(expb));
          checkOutput("busy_in_word", 32'(mon_busy), 32'd1);
          checkOutput("rd_done_in_word", 32'(mon_rd), 32'd0);
        end
      end
    end
    @(negedge clk);
    checkOutput("busy_after_word", 32'(mon_busy), 32'd0);
    checkOutput("txd_after_word", 32'(mon_txd), 32'd1);
  endtask

  initial begin
    logic        found;
    logic [31:0] dropped;
    int          p1;

    // Reset values with a non-empty FIFO.
    reset   = 1'b0;
    tx_hold = 1'b0;
    applyStimulus(1'b0, 32'h0000A55A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("reset_txd", 32'(txd_a), 32'd1);
      checkOutput("reset_busy", 32'(busy_a), 32'd0);
      checkOutput("reset_rd_done", 32'(rd_done_a), 32'd0);
      checkOutput("reset_rd_done_b", 32'(rd_done_b), 32'd0);
    end

    // Single word, popped as soon as reset releases.
    #1 reset = 1'b1;
    #1;
    checkWord(2, -1);
    checkOutput("fifo_empty_after_single", 32'(fifo_empty_a), 32'd1);

    // Back-to-back words.
    applyStimulus(1'b0, 32'h00000001);
    applyStimulus(1'b0, 32'h0000FF00);
    checkWord(2, -1);
    p1 = last_pop;
    checkWord(2, -1);
    checkOutput("b2b_pop_spacing", 32'(last_pop - p1), 32'd81);

    // Hold with three words queued, then hold asserted mid-word.
    tx_hold = 1'b1;
    applyStimulus(1'b0, 32'h00001234);
    applyStimulus(1'b0, 32'h00005678);
    applyStimulus(1'b0, 32'h00009ABC);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("hold_no_pop", 32'(rd_done_a), 32'd0);
      checkOutput("hold_txd", 32'(txd_a), 32'd1);
    end
    tx_hold = 1'b0;
    #1;
    checkWord(2, 20);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("hold_after_word_no_pop", 32'(rd_done_a), 32'd0);
      checkOutput("hold_after_word_busy", 32'(busy_a), 32'd0);
    end
    checkOutput("hold_fifo_not_empty", 32'(fifo_empty_a), 32'd0);
    tx_hold = 1'b0;
    #1;
    checkWord(2, -1);
    checkWord(2, -1);

    // Async reset during bit 3 of byte 0.
    applyStimulus(1'b0, 32'h0000C3C3);
    applyStimulus(1'b0, 32'h00003C3C);
    waitPop(found, dropped);
    if (found) begin
      for (int k = 0; k < 17; k++) @(negedge clk);
      checkOutput("pre_reset_bit3", 32'(txd_a), 32'd0);
      checkOutput("pre_reset_busy", 32'(busy_a), 32'd1);
      #1 reset = 1'b0;
      #1;
      checkOutput("async_reset_txd", 32'(txd_a), 32'd1);
      checkOutput("async_reset_busy", 32'(busy_a), 32'd0);
      checkOutput("async_reset_rd_done", 32'(rd_done_a), 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput("held_reset_txd", 32'(txd_a), 32'd1);
        checkOutput("held_reset_busy", 32'(busy_a), 32'd0);
      end
      #1 reset = 1'b1;
      #1;
      checkWord(2, -1);
    end

    // Wide word on the 32-bit instance.
    @(negedge clk);
    sel = 1'b1;
    applyStimulus(1'b1, 32'hDEADBEEF);
    checkWord(4, -1);
    checkOutput("wide_fifo_empty", 32'(fifo_empty_b), 32'd1);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
